fft_addr_gen: RTL and testbench
===============================

// Module: fft_addr_gen
// PURPOSE
//  Run-time-length radix-2 DIT in-place FFT address sequencer; parametrised successor to the fixed 256-pt ctrl.
//  Sequences a bit-reversed LOAD phase, then log2(L) butterfly stages with optional pipeline-drain gaps.
//  Sits between the SoC control regs and the butterfly datapath / sample RAM / twiddle ROM.
//  Valid/ready on both phases.
// PARAMETERS
//  LOG2N      8  log2 of max FFT length NMAX=2**LOG2N; idx width LOG2N, twiddle width LOG2N-1
//  STAGE_GAP  0  idle cycles (valid low) inserted after each stage except the last (butterfly pipeline drain)
//  CW         $clog2(LOG2N+1)  width of cfg_log2n
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        synchronous active-low reset
//  start      in   1        1-cycle request; sampled only in IDLE
//  abort      in   1        synchronous abort, any state
//  cfg_log2n  in   CW       run length L=2**cfg_log2n; sampled with start
//  ld_valid   out  1        LOAD address valid
//  ld_ready   in   1        sample writer accepts LOAD address
//  ld_cnt     out  LOG2N    natural-order input sample index
//  ld_addr    out  LOG2N    bitrev over cfg_log2n bits of ld_cnt (upper bits 0)
//  bf_valid   out  1        butterfly address pair valid
//  bf_ready   in   1        butterfly accepts pair
//  idx1       out  LOG2N    upper-wing RAM address
//  idx2       out  LOG2N    lower-wing RAM address
//  tw_addr    out  LOG2N-1  twiddle ROM address (ROM sized for NMAX/2)
//  stage      out  CW       current stage s
//  last_bf    out  1        high with final pair of final stage
//  busy       out  1        high from accepted start until done
//  done       out  1        1-cycle pulse after last pair accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0.
//  FSM IDLE->LOAD->CALC(->GAP->CALC)*->DONE->IDLE.
//  - IDLE: start=1 latches Lr=clamp(cfg_log2n,2,LOG2N); next cycle LOAD; busy=1 from that cycle.
//  - LOAD: ld_valid=1, ld_cnt=c; c increments on ld_valid&ld_ready. Accept of c=2**Lr-1 -> CALC, s=0.
//  - CALC: h=1<<s, group base g (step 2h), b in 0..h-1.
//    idx1=g+b; idx2=g+b+h; tw_addr=b<<(LOG2N-1-s).
//    Advance only on bf_valid&bf_ready.
//    Order: b++; at b=h-1 -> b=0, g+=2h; at g=2**Lr-2h -> g=0, s++.
//    Pairs per stage = 2**(Lr-1).
//  - End of stage s<Lr-1: GAP for STAGE_GAP cycles (bf_valid=0), then CALC. STAGE_GAP=0 skips GAP (no bubble).
//  - End of stage s=Lr-1: last_bf was high on that pair; next cycle DONE: done=1, busy=0; next cycle IDLE.
//  - Outputs registered; addresses stable while valid&!ready (no change under stall).
//  - start outside IDLE ignored; cfg_log2n changes after start have no effect.
//  - abort: next cycle IDLE, valids/busy 0, counters 0, no done. abort wins over start in same cycle.
//  - rst_n low mid-run: identical to abort, plus reset values.
//  - Arithmetic: all counters LOG2N bits, no overflow (g+b+h <= 2**Lr-1).
// STRUCTURE
//  Shared package fft_pkg:
//  - state enum {IDLE,LOAD,CALC,GAP,DONE}
//  - clamp_log2n() function
//  - NMAX/width localparams
//  Sub-module fft_bitrev (combinational, LOG2N-wide, masked/shifted to run length Lr) produces ld_addr.
// TESTING
//  1 LOG2N=3, cfg=3, ready tied 1:
//    ld_addr 0,4,2,6,1,5,3,7; then 12 pairs.
//    s0 (0,1)...; s1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; s2 tw 0,1,2,3.
//    done 1 cycle after last_bf.
//  2 LOG2N=8, cfg=4:
//    16 loads, ld_addr of cnt 1 = 8.
//    4 stages x 8 pairs; stage3 tw_addr = b<<4 = 0,16,..,112.
//  3 Random bf_ready/ld_ready stalls: pair sequence identical to test 1; outputs frozen while stalled.
//  4 STAGE_GAP=3, cfg=3: exactly 3 cycles bf_valid=0 between stages 0/1 and 1/2, none after stage 2.
//  5 abort during stage 1 of cfg=8:
//    next cycle busy=0, bf_valid=0, no done.
//    New start runs cleanly from LOAD cnt 0.
//    Same for rst_n=0 pulse.
//  6 Config edge cases:
//    cfg=0 -> runs as L=4 (2 stages).
//    cfg=15 with LOG2N=8 -> L=256.
//    start pulsed mid-run -> ignored, sequence unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the run-time-length FFT address sequencer.
package fft_pkg;

  localparam int unsigned DEF_LOG2N = 8;
  localparam int unsigned MIN_LOG2N = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    GAP,
    DONE
  } state_t;

  // Bound the requested run length to what the butterfly schedule and RAM support.
  function automatic int unsigned clamp_log2n(input int unsigned cfg, input int unsigned lmax);
    if (cfg < MIN_LOG2N) return MIN_LOG2N;
    if (cfg > lmax) return lmax;
    return cfg;
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Bit reversal of a sample index over the active run length lr (upper bits zero).
module fft_bitrev
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = DEF_LOG2N,
  parameter int unsigned CW    = $clog2(LOG2N + 1)
) (
  input  logic [LOG2N-1:0] cnt,
  input  logic [CW-1:0]    lr,
  output logic [LOG2N-1:0] rev
);

  logic [LOG2N-1:0] full;

  // Reverse all LOG2N bits, then slide the result down to the lr-bit field.
  always_comb begin
    full = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      full[i] = cnt[LOG2N-1-i];
    end
    rev = full >> (CW'(LOG2N) - lr);
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT address sequencer: bit-reversed load, then log2(L) butterfly stages.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N     = DEF_LOG2N,
  parameter int unsigned STAGE_GAP = 0,
  parameter int unsigned CW        = $clog2(LOG2N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CW-1:0]    cfg_log2n,
  output logic             ld_valid,
  input  logic             ld_ready,
  output logic [LOG2N-1:0] ld_cnt,
  output logic [LOG2N-1:0] ld_addr,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] idx1,
  output logic [LOG2N-1:0] idx2,
  output logic [LOG2N-2:0] tw_addr,
  output logic [CW-1:0]    stage,
  output logic             last_bf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W1 = LOG2N + 1;
  localparam int unsigned TW = LOG2N - 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [W1-1:0] ONE = W1'(1);

  state_t           state;
  logic [CW-1:0]    lr;
  logic [CW-1:0]    s;
  logic [CW-1:0]    s_nx;
  logic [LOG2N-1:0] c;
  logic [LOG2N-1:0] c_nx;
  logic [LOG2N-1:0] b;
  logic [LOG2N-1:0] b_nx;
  logic [LOG2N-1:0] g;
  logic [LOG2N-1:0] g_nx;
  logic [LOG2N-1:0] rev_nx;
  logic [GW-1:0]    gap_cnt;
  logic [W1-1:0]    n;
  logic [W1-1:0]    h;
  logic [W1-1:0]    h_nx;
  logic             c_last;
  logic             b_last;
  logic             stage_end;
  logic             final_stage;
  logic [LOG2N-1:0] p_idx1;
  logic [LOG2N-1:0] p_idx2;
  logic [TW-1:0]    p_tw;
  logic             p_last;

  // Load address for the next sample index.
  fft_bitrev #(
    .LOG2N(LOG2N),
    .CW   (CW)
  ) u_bitrev (
    .cnt(c_nx),
    .lr (lr),
    .rev(rev_nx)
  );

  // Next butterfly position (b, g, s) and the address pair it produces.
  always_comb begin
    n           = ONE << lr;
    h           = ONE << s;
    c_nx        = c + LOG2N'(1);
    c_last      = ({1'b0, c} == n - ONE);
    b_last      = ({1'b0, b} == h - ONE);
    stage_end   = b_last && ({1'b0, g} == n - (h << 1));
    final_stage = (s == lr - CW'(1));
    b_nx        = b + LOG2N'(1);
    g_nx        = g;
    s_nx        = s;
    if (stage_end) begin
      b_nx = '0;
      g_nx = '0;
      s_nx = s + CW'(1);
    end else if (b_last) begin
      b_nx = '0;
      g_nx = LOG2N'({1'b0, g} + (h << 1));
    end
    h_nx   = ONE << s_nx;
    p_idx1 = g_nx + b_nx;
    p_idx2 = LOG2N'({1'b0, g_nx} + {1'b0, b_nx} + h_nx);
    // b << (TW - s) written as (b << TW) >> s to keep the shift amount non-negative
    p_tw   = TW'({b_nx, TW'(0)} >> s_nx);
    p_last = (s_nx == lr - CW'(1)) && ({1'b0, b_nx} == h_nx - ONE) &&
             ({1'b0, g_nx} == n - (h_nx << 1));
  end

  // Sequencer state, counters and registered outputs; abort behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state    <= IDLE;
      lr       <= '0;
      c        <= '0;
      b        <= '0;
      g        <= '0;
      s        <= '0;
      gap_cnt  <= '0;
      ld_valid <= 1'b0;
      ld_cnt   <= '0;
      ld_addr  <= '0;
      bf_valid <= 1'b0;
      idx1     <= '0;
      idx2     <= '0;
      tw_addr  <= '0;
      stage    <= '0;
      last_bf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lr       <= CW'(clamp_log2n(32'(cfg_log2n), LOG2N));
            state    <= LOAD;
            busy     <= 1'b1;
            ld_valid <= 1'b1;
            c        <= '0;
            ld_cnt   <= '0;
            ld_addr  <= '0;
          end
        end
        LOAD: begin
          if (ld_ready) begin
            if (c_last) begin
              state    <= CALC;
              ld_valid <= 1'b0;
              ld_cnt   <= '0;
              ld_addr  <= '0;
              c        <= '0;
              b        <= '0;
              g        <= '0;
              s        <= '0;
              bf_valid <= 1'b1;
              idx1     <= '0;
              idx2     <= LOG2N'(1);
              tw_addr  <= '0;
              stage    <= '0;
              last_bf  <= 1'b0;
            end else begin
              c       <= c_nx;
              ld_cnt  <= c_nx;
              ld_addr <= rev_nx;
            end
          end
        end
        CALC: begin
          if (bf_ready) begin
            if (stage_end && final_stage) begin
              state    <= DONE;
              bf_valid <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              b        <= '0;
              g        <= '0;
              s        <= '0;
              idx1     <= '0;
              idx2     <= '0;
              tw_addr  <= '0;
              stage    <= '0;
              last_bf  <= 1'b0;
            end else begin
              b       <= b_nx;
              g       <= g_nx;
              s       <= s_nx;
              idx1    <= p_idx1;
              idx2    <= p_idx2;
              tw_addr <= p_tw;
              stage   <= s_nx;
              last_bf <= p_last;
              if (stage_end && (STAGE_GAP != 0)) begin
                state    <= GAP;
                bf_valid <= 1'b0;
                gap_cnt  <= GW'(STAGE_GAP - 1);
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state    <= CALC;
            bf_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: small (LOG2N=3), gapped (STAGE_GAP=3) and full-size (LOG2N=8) instances.
module tb_fft_addr_gen;

  logic clk;
  logic rst_n;
  logic abort;
  logic ld_ready;
  logic bf_ready;

  // shared stimulus for the two LOG2N=3 instances
  logic       start;
  logic [1:0] cfg3;
  // stimulus for the LOG2N=8 instance
  logic       start_b;
  logic [3:0] cfg8;

  logic       ld_valid_a, bf_valid_a, last_bf_a, busy_a, done_a;
  logic [2:0] ld_cnt_a, ld_addr_a, idx1_a, idx2_a;
  logic [1:0] tw_addr_a, stage_a;

  logic       ld_valid_c, bf_valid_c, last_bf_c, busy_c, done_c;
  logic [2:0] ld_cnt_c, ld_addr_c, idx1_c, idx2_c;
  logic [1:0] tw_addr_c, stage_c;

  logic       ld_valid_b, bf_valid_b, last_bf_b, busy_b, done_b;
  logic [7:0] ld_cnt_b, ld_addr_b, idx1_b, idx2_b;
  logic [6:0] tw_addr_b;
  logic [3:0] stage_b;

  int n_tot = 0;
  int n_pass = 0;

  int ld_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int i1_tab[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int i2_tab[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw_tab[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_addr_gen #(.LOG2N(3), .STAGE_GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_log2n(cfg3),
    .ld_valid(ld_valid_a), .ld_ready(ld_ready), .ld_cnt(ld_cnt_a), .ld_addr(ld_addr_a),
    .bf_valid(bf_valid_a), .bf_ready(bf_ready), .idx1(idx1_a), .idx2(idx2_a),
    .tw_addr(tw_addr_a), .stage(stage_a), .last_bf(last_bf_a), .busy(busy_a), .done(done_a)
  );

  fft_addr_gen #(.LOG2N(3), .STAGE_GAP(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_log2n(cfg3),
    .ld_valid(ld_valid_c), .ld_ready(ld_ready), .ld_cnt(ld_cnt_c), .ld_addr(ld_addr_c),
    .bf_valid(bf_valid_c), .bf_ready(bf_ready), .idx1(idx1_c), .idx2(idx2_c),
    .tw_addr(tw_addr_c), .stage(stage_c), .last_bf(last_bf_c), .busy(busy_c), .done(done_c)
  );

  fft_addr_gen #(.LOG2N(8), .STAGE_GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .cfg_log2n(cfg8),
    .ld_valid(ld_valid_b), .ld_ready(ld_ready), .ld_cnt(ld_cnt_b), .ld_addr(ld_addr_b),
    .bf_valid(bf_valid_b), .bf_ready(bf_ready), .idx1(idx1_b), .idx2(idx2_b),
    .tw_addr(tw_addr_b), .stage(stage_b), .last_bf(last_bf_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rev_bits(input int x, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) if (x[i]) r |= 1 << (l - 1 - i);
    return r;
  endfunction

  function automatic int pk3(input int i1, input int i2, input int tw, input int last);
    return (i1 << 6) | (i2 << 3) | (tw << 1) | last;
  endfunction

  function automatic int pkb(input int i1, input int i2, input int tw, input int last);
    return (i1 << 16) | (i2 << 8) | (tw << 1) | last;
  endfunction

  task automatic pulse_a();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Walk one L=8 run on the small instance, optionally with random ready stalls.
  task automatic run_a(input bit stall);
    int c = 0;
    int p = 0;
    int cyc = 0;
    bit rdy;
    while (c < 8 && cyc < 500) begin
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_ready = rdy;
      if (ld_valid_a) begin
        chk("a_load", {ld_cnt_a, ld_addr_a}, (c << 3) | ld_tab[c]);
        if (rdy) c++;
      end
      tick();
      cyc++;
    end
    chk("a_load_count", c, 8);
    while (p < 12 && cyc < 1000) begin
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bf_ready = rdy;
      if (bf_valid_a) begin
        chk("a_pair", {idx1_a, idx2_a, tw_addr_a, last_bf_a},
            pk3(i1_tab[p], i2_tab[p], tw_tab[p], (p == 11) ? 1 : 0));
        if (rdy) p++;
      end
      tick();
      cyc++;
    end
    chk("a_pair_count", p, 12);
    chk("a_done", {done_a, busy_a, bf_valid_a}, 3'b100);
    tick();
    chk("a_done_pulse", {done_a, busy_a}, 2'b00);
    ld_ready = 1'b1;
    bf_ready = 1'b1;
  endtask

  // Walk one run of length 2**l on the large instance; poke re-pulses start with a new cfg mid-load.
  task automatic run_b(input int l, input bit poke);
    int c = 0;
    int cyc = 0;
    int h;
    chk("b_busy", {busy_b, ld_valid_b, ld_cnt_b}, 10'h300);
    while (c < (1 << l) && cyc < 2000) begin
      if (poke && cyc == 3) begin
        start_b = 1'b1;
        cfg8 = 4'd2;
      end else begin
        start_b = 1'b0;
      end
      if (ld_valid_b) begin
        chk("b_load", {ld_cnt_b, ld_addr_b}, (c << 8) | rev_bits(c, l));
        c++;
      end
      tick();
      cyc++;
    end
    start_b = 1'b0;
    chk("b_load_count", c, 1 << l);
    for (int s = 0; s < l; s++) begin
      h = 1 << s;
      for (int g = 0; g < (1 << l); g += 2 * h) begin
        for (int b = 0; b < h; b++) begin
          cyc = 0;
          while (!bf_valid_b && cyc < 50) begin
            tick();
            cyc++;
          end
          chk("b_pair", {idx1_b, idx2_b, tw_addr_b, last_bf_b},
              pkb(g + b, g + b + h, b << (7 - s), (s == l - 1 && b == h - 1) ? 1 : 0));
          tick();
        end
      end
    end
    chk("b_done", {done_b, busy_b, bf_valid_b}, 3'b100);
    tick();
  endtask

  initial begin
    int cyc;
    int p;
    int gap;
    int seen;

    rst_n    = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    start_b  = 1'b0;
    cfg3     = 2'd3;
    cfg8     = 4'd4;
    ld_ready = 1'b1;
    bf_ready = 1'b1;
    repeat (3) tick();
    chk("rst_a", {ld_valid_a, ld_cnt_a, ld_addr_a, bf_valid_a, idx1_a, idx2_a, tw_addr_a,
                  stage_a, last_bf_a, busy_a, done_a}, 0);
    chk("rst_b", {ld_valid_b, ld_cnt_b, ld_addr_b, bf_valid_b, idx1_b, idx2_b, busy_b, done_b}, 0);
    chk("rst_b_tw", {tw_addr_b, stage_b, last_bf_b}, 0);
    rst_n = 1'b1;
    tick();

    // L=8, ready always high
    pulse_a();
    chk("a_busy", busy_a, 1);
    run_a(1'b0);

    // same run with random stalls on both handshakes
    repeat (40) tick();
    pulse_a();
    run_a(1'b1);

    // gapped instance: 3 idle cycles between stages, none after the last
    repeat (40) tick();
    chk("c_idle", busy_c, 0);
    pulse_a();
    p = 0;
    gap = 0;
    cyc = 0;
    while (p < 12 && cyc < 200) begin
      if (bf_valid_c) begin
        chk("c_pair", {idx1_c, idx2_c, tw_addr_c, last_bf_c},
            pk3(i1_tab[p], i2_tab[p], tw_tab[p], (p == 11) ? 1 : 0));
        if (p == 4 || p == 8) chk("c_gap", gap, 3);
        gap = 0;
        p++;
      end else if (p > 0) begin
        gap++;
      end
      tick();
      cyc++;
    end
    chk("c_pair_count", p, 12);
    chk("c_done", {done_c, busy_c}, 2'b10);
    repeat (20) tick();

    // LOG2N=8, cfg=4: 16 loads, 4 stages x 8 pairs
    cfg8 = 4'd4;
    pulse_b();
    run_b(4, 1'b0);

    // abort during stage 1 of a 256-point run
    cfg8 = 4'd8;
    pulse_b();
    cyc = 0;
    while (!(bf_valid_b && stage_b == 4'd1) && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("b_reach_stage1", {bf_valid_b, stage_b}, 5'h11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b_abort", {busy_b, bf_valid_b, done_b, ld_valid_b, stage_b, idx1_b}, 0);
    seen = 0;
    repeat (4) begin
      if (done_b) seen = 1;
      tick();
    end
    chk("b_abort_no_done", seen, 0);

    // abort beats start in the same cycle
    start_b = 1'b1;
    abort = 1'b1;
    tick();
    start_b = 1'b0;
    abort = 1'b0;
    chk("b_abort_over_start", {busy_b, ld_valid_b}, 0);

    // clean restart after abort
    cfg8 = 4'd4;
    pulse_b();
    run_b(4, 1'b0);

    // reset pulse mid-load
    pulse_b();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("b_rst_mid", {busy_b, ld_valid_b, ld_cnt_b, ld_addr_b, bf_valid_b, done_b}, 0);
    tick();
    chk("b_rst_idle", {busy_b, done_b}, 0);

    // cfg below minimum runs as L=4
    cfg8 = 4'd0;
    pulse_b();
    run_b(2, 1'b0);

    // cfg above LOG2N runs as L=256, mid-run start with new cfg ignored
    cfg8 = 4'd15;
    pulse_b();
    run_b(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
